// File: rtl/sum_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_collector_if
// Brief    : Result-in pulse and result-out valid/ready bundle for the collector.
// Revision : 1.0  initial release
// ============================================================================
interface sum_result_collector_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // master: adder stage plus downstream consumer; slave: the collector
    modport master (
        output in_valid, in_y, out_ready,
        input  out_valid, out_data
    );
    modport slave (
        input  in_valid, in_y, out_ready,
        output out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/sum_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_collector
// Brief    : FWFT result FIFO with saturating accumulator and drop counter.
// Revision : 1.0  initial release
// ============================================================================
module sum_result_collector #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    sum_result_collector_if.slave           bus,
    input  wire logic                       clr,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic [ACC_W-1:0]                acc,
    output logic                            acc_sat,
    output logic [7:0]                      drop_cnt
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [7:0]         c_DROP_MAX  = 8'hFF;
    localparam logic [ACC_W-1:0]   c_ACC_MAX   = {ACC_W{1'b1}};

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_sat;
    logic [7:0]         r_drop_cnt;

    logic               w_out_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ACC_W-1:0]   w_y_ext;
    logic [ACC_W:0]     w_acc_sum;

    assign w_out_valid = (r_count != '0);
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_push      = bus.in_valid && (!w_full || w_pop);
    assign w_drop      = bus.in_valid && w_full && !w_pop;
    assign w_y_ext     = {{(ACC_W-W){1'b0}}, bus.in_y};
    assign w_acc_sum   = {1'b0, r_acc} + {1'b0, w_y_ext};

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Statistics; clr restarts them but still counts this cycle's event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_acc_sat  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                if (clr) begin
                    r_acc     <= w_y_ext;
                    r_acc_sat <= 1'b0;
                end else if (w_acc_sum[ACC_W]) begin
                    r_acc     <= c_ACC_MAX;
                    r_acc_sat <= 1'b1;
                end else begin
                    r_acc     <= w_acc_sum[ACC_W-1:0];
                end
            end else if (clr) begin
                r_acc     <= '0;
                r_acc_sat <= 1'b0;
            end

            if (clr) begin
                r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
            end else if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count         = r_count;
    assign full          = w_full;
    assign acc           = r_acc;
    assign acc_sat       = r_acc_sat;
    assign drop_cnt      = r_drop_cnt;

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_DEPTH_CNT);
    a_full_match: assert property (@(posedge clk) disable iff (!rst_n)
        full == (count == c_DEPTH_CNT));
    a_valid_match: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid == (count != '0));
    a_drop_mono: assert property (@(posedge clk) disable iff (!rst_n)
        !clr |=> (drop_cnt >= $past(drop_cnt)));
    a_push_grows: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.in_valid && !full) |=> (count >= $past(count)));
`endif
endmodule
`default_nettype wire

// File: tb/tb_sum_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_result_collector
// Brief    : Queue-based reference model bench with directed and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_result_collector;
    localparam int c_DEPTH = 4;
    localparam int c_ACC_MAX = 65535;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] count;
    logic       full;
    logic [15:0] acc;
    logic       acc_sat;
    logic [7:0] drop_cnt;

    int n_err = 0;
    int n_chk = 0;

    sum_result_collector_if #(.W(8)) bus ();

    sum_result_collector #(.W(8), .DEPTH(c_DEPTH), .ACC_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr      (clr),
        .count    (count),
        .full     (full),
        .acc      (acc),
        .acc_sat  (acc_sat),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue plus plain integer statistics
    logic [7:0] m_q[$];
    int         m_acc  = 0;
    bit         m_sat  = 1'b0;
    int         m_drop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_acc  = 0;
            m_sat  = 1'b0;
            m_drop = 0;
        end else begin
            bit pop, push, drop, was_full;
            was_full = (m_q.size() == c_DEPTH);
            pop  = (m_q.size() != 0) && bus.out_ready;
            push = bus.in_valid && (!was_full || pop);
            drop = bus.in_valid && was_full && !pop;
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(bus.in_y);
            if (push) begin
                if (clr) begin
                    m_acc = int'(bus.in_y);
                    m_sat = 1'b0;
                end else if (m_acc + int'(bus.in_y) > c_ACC_MAX) begin
                    m_acc = c_ACC_MAX;
                    m_sat = 1'b1;
                end else begin
                    m_acc = m_acc + int'(bus.in_y);
                end
            end else if (clr) begin
                m_acc = 0;
                m_sat = 1'b0;
            end
            if (clr) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 255) m_drop = m_drop + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("out_data",  32'(bus.out_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("count",     32'(count),         32'(m_q.size()));
        chk("full",      32'(full),          32'(m_q.size() == c_DEPTH));
        chk("acc",       32'(acc),           32'(m_acc));
        chk("acc_sat",   32'(acc_sat),       32'(m_sat));
        chk("drop_cnt",  32'(drop_cnt),      32'(m_drop));
    end

    task automatic step(input bit v, input logic [7:0] y, input bit rdy, input bit c);
        bus.in_valid  = v;
        bus.in_y      = y;
        bus.out_ready = rdy;
        clr           = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_order [4];
        bus.in_valid  = 1'b0;
        bus.in_y      = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;

        // Single pulse, then pop
        step(1, 8'h2A, 0, 0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data",  32'(bus.out_data), 32'h2A);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_acc",   32'(acc), 32'h002A);
        step(0, 8'h00, 1, 0);
        chk("t1_pop_count", 32'(count), 32'd0);
        chk("t1_pop_data",  32'(bus.out_data), 32'd0);

        // Overfill by one, then drain in order
        step(0, 8'h00, 0, 1);
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_full",  32'(full), 32'd1);
        chk("t2_drop",  32'(drop_cnt), 32'd1);
        chk("t2_acc",   32'(acc), 32'h000A);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", 32'(bus.out_data), 32'(i));
            step(0, 8'h00, 1, 0);
        end

        // Push while full with simultaneous pop
        for (int i = 0; i < 4; i++) step(1, 8'(8'h11 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        chk("t3_drop",  32'(drop_cnt), 32'd1);
        chk("t3_count", 32'(count), 32'd4);
        exp_order = '{8'h12, 8'h13, 8'h14, 8'h77};
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", 32'(bus.out_data), 32'(exp_order[i]));
            step(0, 8'h00, 1, 0);
        end

        // Accumulator saturation
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 257; i++) step(1, 8'hFF, 1, 0);
        chk("t4_acc_257", 32'(acc), 32'hFFFF);
        chk("t4_sat_257", 32'(acc_sat), 32'd0);
        step(1, 8'hFF, 1, 0);
        chk("t4_sat_258", 32'(acc_sat), 32'd1);
        step(0, 8'h00, 0, 1);
        chk("t4_clr_acc",  32'(acc), 32'd0);
        chk("t4_clr_sat",  32'(acc_sat), 32'd0);
        chk("t4_clr_drop", 32'(drop_cnt), 32'd0);
        chk("t4_fifo",     32'(bus.out_data), 32'hFF);
        step(0, 8'h00, 1, 0);

        // clr concurrent with push / with drop
        step(1, 8'h10, 0, 1);
        chk("t5_acc", 32'(acc), 32'h0010);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0);
        step(1, 8'h99, 0, 1);
        chk("t5_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_acc",   32'(acc), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 8'h00, 0, 0);
        chk("t6_idle_valid", 32'(bus.out_valid), 32'd0);
        step(1, 8'h33, 0, 0);
        chk("t6_first", 32'(bus.out_data), 32'h33);
        for (int i = 0; i < 3; i++) step(1, 8'h01, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 8'h05, 0, 0);
        chk("t6_drop_sat", 32'(drop_cnt), 32'd255);

        // Random traffic
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6,
                 ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 2);
        end
        step(0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sum_result_collector.md
Name: sum_result_collector

Overview:
Downstream consumer of the registered adder stage. Captures each single-cycle result pulse (in_valid/in_y) into a DEPTH-entry first-word-fall-through FIFO and presents results to the next stage through a valid/ready handshake. Keeps running statistics alongside the FIFO: a saturating sum of accepted results and a saturating count of dropped results. The adder stage has no backpressure, so this block absorbs result bursts and reports overflow instead of stalling.

Parameters:
W, 8, result data width; matches adder output width.
DEPTH, 4, FIFO entries; power of two, at least 2.
ACC_W, 16, accumulator width; must satisfy ACC_W > W.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  result pulse from the adder stage; one cycle per result.
in_y  input  W  result data; sampled only when in_valid=1.
clr  input  1  synchronous clear of the statistics (acc, acc_sat, drop_cnt); does not flush the FIFO.
out_valid  output  1  FIFO non-empty; out_data holds the oldest entry.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  W  oldest FIFO entry; 0 when empty.
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
full  output  1  count==DEPTH.
acc  output  ACC_W  saturating sum of accepted results.
acc_sat  output  1  sticky flag: acc has saturated.
drop_cnt  output  8  results dropped because the FIFO was full; saturates at 255.

Behaviour:
- Reset (async, rst_n=0): count=0, out_valid=0, out_data=0, full=0, acc=0, acc_sat=0, drop_cnt=0, read/write pointers=0.
- pop = out_valid && out_ready.
- push = in_valid && (!full || pop). A push while full is allowed only when a pop occurs in the same cycle.
- Latency: a push into an empty FIFO makes out_valid=1, with out_data=in_y, on the next cycle. There is no same-cycle bypass. out_valid is never asserted combinationally from in_valid.
- All outputs are driven from registers or a register-indexed storage read. No combinational path runs from in_valid/in_y to any output.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers: log2(DEPTH) bits; wrap naturally from DEPTH-1 to 0. count tracks occupancy independently of the pointers.
- Drop: in_valid && full && !pop. in_y is discarded, FIFO contents are unchanged, and drop_cnt increments unless it is already 255.
- out_ready while empty: no effect; count never underflows.
- Ordering: strict FIFO. Results exit in arrival order with no loss except counted drops.
- Accumulator: on push, acc <= min(acc + zero_extend(in_y), 2^ACC_W-1). acc_sat is set when saturation occurs and stays set until clr or reset. Dropped results are not accumulated.
- clr (synchronous, statistics only):
  - clr alone: acc=0, acc_sat=0, drop_cnt=0 on the next edge.
  - clr with push in the same cycle: acc <= in_y, acc_sat <= 0.
  - clr with drop in the same cycle: drop_cnt <= 1.
  - The FIFO, count and pointers are unaffected by clr.
- Reset mid-operation: the FIFO contents are discarded immediately. No out_valid is asserted until a new push occurs after reset is released.
- Assertions to embed:
  - count <= DEPTH.
  - full == (count==DEPTH).
  - out_valid == (count!=0).
  - drop_cnt never decrements, except via clr or reset.
  - in_valid && !full implies count increases or stays equal (the latter when a pop occurs).

Test Plan:
1. Reset, then a single pulse in_y=0x2A with out_ready=0 -> next cycle out_valid=1, out_data=0x2A, count=1, acc=0x002A. Assert out_ready for one cycle -> count=0, out_valid=0, out_data=0.
2. out_ready=0, five pulses 0x01..0x05 (DEPTH=4) -> count=4, full=1, drop_cnt=1, acc=0x000A. Then drain with out_ready=1 -> outputs 0x01,0x02,0x03,0x04 in order.
3. FIFO full with out_ready=1 and in_valid=1 (in_y=0x77) in the same cycle -> drop_cnt unchanged, count stays 4, 0x77 exits after the three remaining older entries.
4. Push 0xFF repeatedly with out_ready=1, ACC_W=16: 257 pushes give acc=0xFFFF (65535), acc_sat=1 on the 258th push. Then clr alone -> acc=0, acc_sat=0, drop_cnt=0, FIFO contents intact.
5. clr concurrent with a push of 0x10 -> acc=0x0010 next cycle. clr concurrent with a drop -> drop_cnt=1.
6. Fill 3 entries, pulse rst_n low mid-cycle (asynchronous) -> count=0, out_valid=0, acc=0 immediately. After release, a push of 0x33 appears as the first out_data. Run 300 drops -> drop_cnt holds at 255.
